// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice adder; exposes the carry into its top bit for overflow.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum      = full[CHUNK-1:0];
    assign cout     = full[CHUNK];
    // Carry into the top bit recovered from the top-bit sum identity.
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined add/subtract unit with operand skew, result deskew and a
// single global advance enable driven by the output handshake.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    // b chunks still to be consumed, packed triangularly: stage k keeps STAGES-k chunks.
    localparam int BTOT  = CHUNK * STAGES * (STAGES + 1) / 2;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic             valid_q [STAGES];
    logic [WIDTH-1:0] word_q  [STAGES];
    logic             carry_q [STAGES];
    logic [BTOT-1:0]  b_tri_q;

    logic [CHUNK-1:0] sum_c  [STAGES];
    logic             cout_c [STAGES];
    logic             cmsb_c [STAGES];

    logic [WIDTH-1:0] result_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = !rst_n || adv;
    assign b_eff    = (sub == SUB) ? ~b : b;
    assign cin_eff  = c_in ^ sub;

    // word_q[k] holds finished sum chunks below chunk k and still-pending a chunks above.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            localparam int BOFF = CHUNK * (gi * STAGES - (gi * (gi - 1)) / 2);
            localparam int BW   = (STAGES - gi) * CHUNK;

            adder_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a        (word_q[gi][gi*CHUNK +: CHUNK]),
                .b        (b_tri_q[BOFF +: CHUNK]),
                .cin      (carry_q[gi]),
                .sum      (sum_c[gi]),
                .cout     (cout_c[gi]),
                .c_msb_in (cmsb_c[gi])
            );

            if (gi == 0) begin : g_load
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        valid_q[0]            <= 1'b0;
                        word_q[0]             <= '0;
                        b_tri_q[BOFF +: BW]   <= '0;
                        carry_q[0]            <= 1'b0;
                    end else if (adv) begin
                        valid_q[0]            <= in_valid;
                        word_q[0]             <= a;
                        b_tri_q[BOFF +: BW]   <= b_eff;
                        carry_q[0]            <= cin_eff;
                    end
                end
            end else begin : g_shift
                localparam int PBOFF = CHUNK * ((gi - 1) * STAGES - ((gi - 1) * (gi - 2)) / 2);
                logic [WIDTH-1:0] word_d;

                always_comb begin
                    word_d = word_q[gi-1];
                    word_d[(gi-1)*CHUNK +: CHUNK] = sum_c[gi-1];
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        valid_q[gi]           <= 1'b0;
                        word_q[gi]            <= '0;
                        b_tri_q[BOFF +: BW]   <= '0;
                        carry_q[gi]           <= 1'b0;
                    end else if (adv) begin
                        valid_q[gi]           <= valid_q[gi-1];
                        word_q[gi]            <= word_d;
                        b_tri_q[BOFF +: BW]   <= b_tri_q[PBOFF+CHUNK +: BW];
                        carry_q[gi]           <= cout_c[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        result_d = word_q[STAGES-1];
        result_d[(STAGES-1)*CHUNK +: CHUNK] = sum_c[STAGES-1];
    end

    // Output data only reloads on a real result so idle outputs stay quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= valid_q[STAGES-1];
            if (valid_q[STAGES-1]) begin
                sum_q   <= result_d;
                c_out_q <= cout_c[STAGES-1];
                ovf_q   <= cmsb_c[STAGES-1] ^ cout_c[STAGES-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed table, stall/reset sequences and streaming sweeps for an 8-bit, 4-stage pipelined_adder.
module tb_pipelined_adder;
    import adder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(.WIDTH(8), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: sum/carry from a wide add, overflow from operand/result sign rule.
    function automatic logic [9:0] model(input logic [7:0] a_m, input logic [7:0] b_m,
                                         input logic cin_m, input logic sub_m);
        logic [7:0] be;
        logic [8:0] full;
        logic       ov;
        be   = sub_m ? ~b_m : b_m;
        full = {1'b0, a_m} + {1'b0, be} + {8'd0, cin_m ^ sub_m};
        ov   = (a_m[7] == be[7]) && (full[7] != a_m[7]);
        return {full[8], ov, full[7:0]};
    endfunction

    // Single isolated operation: checks acceptance, 4-cycle latency and result fields.
    task automatic run_one(input vec_t v);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = v.a; b = v.b; c_in = v.cin; sub = v.sub;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #2;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", 32'(lat), 32'd4);
        check("sum", 32'(sum), 32'(v.sum));
        check("c_out", 32'(c_out), 32'(v.cout));
        check("ovf", 32'(ovf), 32'(v.ovf));
        $display("op a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h c_out=%0d ovf=%0d lat=%0d",
                 v.a, v.b, v.cin, v.sub, sum, c_out, ovf, lat);
    endtask

    // Streaming run with scoreboard; full-rate mode also checks one result per cycle.
    task automatic stream(input int n, input bit rand_ready, input bit sweep);
        logic [9:0] q[$];
        logic [9:0] exp_v;
        logic [7:0] b_tab [8];
        int sent, recv, t, first, last, budget;
        bit in_v;
        b_tab = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h3C};
        sent = 0; recv = 0; t = 0; first = -1; last = -1;
        budget = 4 * n + 50;
        while (recv < n && t < budget) begin
            @(posedge clk); #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_v = (sent < n) && (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (sweep) begin
                a    = sent[7:0];
                b    = b_tab[sent[10:8]];
                c_in = sent[11];
                sub  = sent[12];
            end else begin
                a    = 8'($urandom);
                b    = 8'($urandom);
                c_in = 1'($urandom);
                sub  = 1'($urandom);
            end
            in_valid = in_v;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 32'd1, 32'd0);
                end else begin
                    exp_v = q.pop_front();
                    check("stream_result", 32'({c_out, ovf, sum}), 32'(exp_v));
                end
                recv++;
                if (first < 0) first = t;
                last = t;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                sent++;
            end
            t++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(recv), 32'(n));
        if (!rand_ready) check("throughput", 32'(last - first), 32'(n - 1));
        $display("stream n=%0d rand_ready=%0d sweep=%0d received=%0d cycles=%0d",
                 n, rand_ready, sweep, recv, t);
    endtask

    // 16 back-to-back operations with out_ready low for cycles 8..10.
    task automatic stall_stream();
        vec_t       v [16];
        logic [9:0] q[$];
        logic [9:0] exp_v;
        logic [9:0] held;
        bit         was_held;
        int sent, recv, t;
        for (int i = 0; i < 16; i++) begin
            v[i].a   = 8'($urandom);
            v[i].b   = 8'($urandom);
            v[i].cin = 1'($urandom);
            v[i].sub = 1'($urandom);
        end
        sent = 0; recv = 0; t = 0; was_held = 1'b0; held = '0;
        while ((recv < 16 || t <= 20) && t < 80) begin
            @(posedge clk); #1;
            out_ready = !(t >= 8 && t <= 10);
            in_valid  = (sent < 16);
            if (sent < 16) begin
                a = v[sent].a; b = v[sent].b; c_in = v[sent].cin; sub = v[sent].sub;
            end
            #1;
            if (t <= 20) check("stall_in_ready", 32'(in_ready), 32'(!(t >= 8 && t <= 10)));
            if (was_held) begin
                check("held_valid", 32'(out_valid), 32'd1);
                check("held_outputs", 32'({c_out, ovf, sum}), 32'(held));
            end
            was_held = out_valid && !out_ready;
            held     = {c_out, ovf, sum};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stall_spurious", 32'd1, 32'd0);
                end else begin
                    exp_v = q.pop_front();
                    check("stall_result", 32'({c_out, ovf, sum}), 32'(exp_v));
                    $display("stall stream result %0d: sum=%02h c_out=%0d ovf=%0d", recv, sum, c_out, ovf);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                sent++;
            end
            t++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_count", 32'(recv), 32'd16);
    endtask

    // Reset with three operations in flight, then a fresh operation.
    task automatic reset_flight();
        vec_t v;
        int   seen;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            a = 8'(8'h10 + i); b = 8'h22; c_in = 1'b0; sub = ADD;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("in_ready_in_reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", 32'({c_out, ovf}), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #2;
            if (out_valid) seen++;
        end
        check("flight_discarded", 32'(seen), 32'd0);
        $display("reset with 3 in flight: outputs seen afterwards=%0d", seen);
        v = '{a: 8'h33, b: 8'h44, cin: 1'b0, sub: ADD, sum: 8'h77, cout: 1'b0, ovf: 1'b0};
        run_one(v);
    endtask

    vec_t table_v [10];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = ADD;
        table_v[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: ADD, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        table_v[1] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: ADD, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        table_v[2] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sub: ADD, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        table_v[3] = '{a: 8'h05, b: 8'h07, cin: 1'b0, sub: SUB, sum: 8'hFE, cout: 1'b0, ovf: 1'b0};
        table_v[4] = '{a: 8'h05, b: 8'h07, cin: 1'b1, sub: SUB, sum: 8'hFD, cout: 1'b0, ovf: 1'b0};
        table_v[5] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: SUB, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
        table_v[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sub: ADD, sum: 8'h47, cout: 1'b0, ovf: 1'b0};
        table_v[7] = '{a: 8'h07, b: 8'h05, cin: 1'b0, sub: SUB, sum: 8'h02, cout: 1'b1, ovf: 1'b0};
        table_v[8] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sub: SUB, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        table_v[9] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: ADD, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};

        repeat (2) @(posedge clk);
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_one(table_v[i]);
        stall_stream();
        reset_flight();
        stream(8192, 1'b0, 1'b1);
        stream(2000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
